// File: rtl/ex_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative RV32M multiply/divide unit:
//   - REG_DATA_WIDTH : register file / operand width of the core
//   - md_state_t     : sequencer state encoding (IDLE, CALC, DONE)
//   - MD_MUL..MD_REMU: funct3 encodings of the M-extension operations
//   - is_signed_rs1/is_signed_rs2 : which operands are treated as signed
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int REG_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_t;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    // rs1 is signed for MULH, MULHSU, DIV and REM
    function automatic logic is_signed_rs1(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV)  || (op == MD_REM);
    endfunction

    // rs2 is signed for MULH, DIV and REM (MULHSU treats rs2 as unsigned)
    function automatic logic is_signed_rs2(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// -----------------------------------------------------------------------------
// ex_muldiv
// Iterative RV32M multiply/divide unit in the Execute stage. One radix-2 step
// per cycle over magnitudes; signs are re-applied when the last step retires.
// Multiplier (shift-add) and divider (restoring) share one counter and one
// 2*XLEN accumulator. Divide-by-zero and signed overflow finish in one cycle.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : kill the in-flight op; wins over start
//   hold          : downstream stall, keeps DONE (and the result) alive
//   start, op     : valid M op in EX and its funct3
//   rs1_val/rs2_val: forwarded operands
//   result, result_valid : registered result, valid while in DONE
//   stall_req     : freezes IF/ID/EX while the unit needs more cycles
//   busy          : unit is not IDLE
// -----------------------------------------------------------------------------
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = REG_DATA_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            hold,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            stall_req,
    output logic            busy
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);

    md_state_t          state_r;
    md_state_t          state_s;
    logic [CW-1:0]      cnt_r;
    logic [2:0]         op_r;
    logic [XLEN-1:0]    bmag_r;      // |rs2|: multiplicand or divisor
    logic [2*XLEN-1:0]  acc_r;       // {hi/remainder, lo/quotient}
    logic               neg_q_r;     // product / quotient must be negated
    logic               neg_rem_r;   // remainder must be negated
    logic [XLEN-1:0]    result_r;
    logic               result_valid_r;
    logic               busy_r;

    logic               a_neg_s;
    logic               b_neg_s;
    logic [XLEN-1:0]    a_mag_s;
    logic [XLEN-1:0]    b_mag_s;
    logic               div_zero_s;
    logic               ovf_s;
    logic               special_s;
    logic [XLEN-1:0]    special_val_s;
    logic               accept_s;

    logic [XLEN:0]      mul_sum_s;
    logic [2*XLEN-1:0]  mul_next_s;
    logic [XLEN:0]      div_rem_sh_s;
    logic [XLEN:0]      div_diff_s;
    logic [2*XLEN-1:0]  div_next_s;
    logic [2*XLEN-1:0]  step_s;
    logic [2*XLEN-1:0]  prod_s;
    logic [XLEN-1:0]    quot_s;
    logic [XLEN-1:0]    rem_s;
    logic [XLEN-1:0]    fin_s;

    // Operand conditioning: signs, magnitudes and single-cycle special cases
    assign a_neg_s    = is_signed_rs1(op) & rs1_val[XLEN-1];
    assign b_neg_s    = is_signed_rs2(op) & rs2_val[XLEN-1];
    assign a_mag_s    = a_neg_s ? ({XLEN{1'b0}} - rs1_val) : rs1_val;
    assign b_mag_s    = b_neg_s ? ({XLEN{1'b0}} - rs2_val) : rs2_val;
    assign div_zero_s = (rs2_val == {XLEN{1'b0}});
    assign ovf_s      = is_signed_rs1(op) &
                        (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &
                        (rs2_val == {XLEN{1'b1}});
    assign special_s  = op[2] & (div_zero_s | ovf_s);
    assign accept_s   = start & ~flush;

    // Special-case divide results; op[1] separates REM* from DIV*
    always_comb begin
        special_val_s = {XLEN{1'b1}};
        if (div_zero_s) begin
            if (op[1]) begin
                special_val_s = rs1_val;
            end else begin
                special_val_s = {XLEN{1'b1}};
            end
        end else begin
            if (op[1]) begin
                special_val_s = {XLEN{1'b0}};
            end else begin
                special_val_s = {1'b1, {(XLEN-1){1'b0}}};
            end
        end
    end

    // Shift-add multiply step: add multiplicand to the high half when the
    // multiplier LSB is set, then shift the whole accumulator right by one.
    assign mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                        (acc_r[0] ? {1'b0, bmag_r} : {(XLEN+1){1'b0}});
    assign mul_next_s = {mul_sum_s, acc_r[XLEN-1:1]};

    // Restoring divide step: shift the next dividend bit into the partial
    // remainder and subtract; the borrow bit of the difference decides.
    assign div_rem_sh_s = acc_r[2*XLEN-1:XLEN-1];
    assign div_diff_s   = div_rem_sh_s - {1'b0, bmag_r};

    // Pick restored or reduced remainder and shift in the quotient bit
    always_comb begin
        div_next_s = acc_r;
        if (div_diff_s[XLEN] == 1'b0) begin
            div_next_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
        end else begin
            div_next_s = {div_rem_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
        end
    end

    assign step_s = op_r[2] ? div_next_s : mul_next_s;

    // Sign fix-up applied to the value produced by the final step
    assign prod_s = neg_q_r   ? ({(2*XLEN){1'b0}} - step_s) : step_s;
    assign quot_s = neg_q_r   ? ({XLEN{1'b0}} - step_s[XLEN-1:0]) : step_s[XLEN-1:0];
    assign rem_s  = neg_rem_r ? ({XLEN{1'b0}} - step_s[2*XLEN-1:XLEN]) : step_s[2*XLEN-1:XLEN];

    // Final result selection by operation
    always_comb begin
        fin_s = {XLEN{1'b0}};
        case (op_r)
            MD_MUL:    fin_s = prod_s[XLEN-1:0];
            MD_MULH,
            MD_MULHSU,
            MD_MULHU:  fin_s = prod_s[2*XLEN-1:XLEN];
            MD_DIV,
            MD_DIVU:   fin_s = quot_s;
            MD_REM,
            MD_REMU:   fin_s = rem_s;
            default:   fin_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic; flush wins from any state, DONE ignores start
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_s = special_s ? DONE : CALC;
                    end else begin
                        state_s = IDLE;
                    end
                end
                CALC: begin
                    if (cnt_r == LAST_CNT) begin
                        state_s = DONE;
                    end else begin
                        state_s = CALC;
                    end
                end
                DONE: begin
                    if (hold) begin
                        state_s = DONE;
                    end else begin
                        state_s = IDLE;
                    end
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            cnt_r          <= {CW{1'b0}};
            op_r           <= 3'b000;
            bmag_r         <= {XLEN{1'b0}};
            acc_r          <= {(2*XLEN){1'b0}};
            neg_q_r        <= 1'b0;
            neg_rem_r      <= 1'b0;
            result_r       <= {XLEN{1'b0}};
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            result_valid_r <= (state_s == DONE);
            busy_r         <= (state_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r      <= op;
                        bmag_r    <= b_mag_s;
                        acc_r     <= {{XLEN{1'b0}}, a_mag_s};
                        neg_q_r   <= a_neg_s ^ b_neg_s;
                        neg_rem_r <= a_neg_s;
                        cnt_r     <= {CW{1'b0}};
                        if (special_s) begin
                            result_r <= special_val_s;
                        end
                    end
                end
                CALC: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r + CW'(1);
                    if ((cnt_r == LAST_CNT) && !flush) begin
                        result_r <= fin_s;
                    end
                end
                DONE: begin
                    result_r <= result_r;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign stall_req    = ((state_r == IDLE) & accept_s) |
                          (state_r == CALC) |
                          ((state_r == DONE) & hold);
    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// -----------------------------------------------------------------------------
// tb_ex_muldiv
// Scoreboard bench for ex_muldiv: the driver pushes the expected result of each
// accepted op, a monitor pops and compares whenever the final DONE cycle is
// presented. Expected values come from directed constants or from a plain
// 64-bit arithmetic model of the RV32M operations.
// -----------------------------------------------------------------------------
module tb_ex_muldiv;

    localparam logic [2:0] T_MUL    = 3'd0;
    localparam logic [2:0] T_MULH   = 3'd1;
    localparam logic [2:0] T_MULHSU = 3'd2;
    localparam logic [2:0] T_MULHU  = 3'd3;
    localparam logic [2:0] T_DIV    = 3'd4;
    localparam logic [2:0] T_DIVU   = 3'd5;
    localparam logic [2:0] T_REM    = 3'd6;
    localparam logic [2:0] T_REMU   = 3'd7;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        hold;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] result;
    logic        result_valid;
    logic        stall_req;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb_q[$];

    ex_muldiv #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .hold         (hold),
        .start        (start),
        .op           (op),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .result       (result),
        .result_valid (result_valid),
        .stall_req    (stall_req),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model straight from the RV32M definitions
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        int          ai;
        int          bi;
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        ai = a;
        bi = b;
        sa = ai;
        sb = bi;
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 64'd0;
        case (o)
            T_MUL:    begin p = ua * ub; return p[31:0];  end
            T_MULH:   begin p = sa * sb; return p[63:32]; end
            T_MULHSU: begin p = sa * ub; return p[63:32]; end
            T_MULHU:  begin p = ua * ub; return p[63:32]; end
            T_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            T_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            T_DIVU: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
        if (o[2] && b == 32'd0) return 1;
        if ((o == T_DIV || o == T_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Monitor: compare on the last DONE cycle (the one the pipeline consumes)
    always @(negedge clk) begin
        if (!rst && result_valid && !hold) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %h with no pending op", result);
            end else begin
                chk("result", result, sb_q.pop_front());
            end
        end
    end

    // Issue one op and hold start until the unit lets the pipeline advance
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int hold_cyc, input int exp_lat);
        int cyc;
        int stall_cnt;
        bit got;
        sb_q.push_back(exp);
        op        = o;
        rs1_val   = a;
        rs2_val   = b;
        start     = 1'b1;
        cyc       = 0;
        stall_cnt = 0;
        got       = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            if (stall_req) stall_cnt++;
            @(posedge clk);
            #1;
            cyc++;
            if (result_valid) got = 1'b1;
        end
        if (!got) begin
            chk("timeout", 32'(got), 32'd1);
            void'(sb_q.pop_back());
            start = 1'b0;
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
        end else begin
            chk("latency", 32'(cyc), 32'(exp_lat));
            chk("stall_cycles", 32'(stall_cnt), 32'(cyc));
            if (hold_cyc > 0) begin
                hold = 1'b1;
                repeat (hold_cyc) begin
                    @(posedge clk);
                    #1;
                    chk("hold_valid", {31'd0, result_valid}, 32'd1);
                    chk("hold_result", result, exp);
                end
                hold = 1'b0;
            end
            @(negedge clk);
            chk("done_stall", {31'd0, stall_req}, 32'd0);
            @(posedge clk);
            #1;
            start = 1'b0;
            chk("idle_after_done", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        bit          seen;
        rst     = 1'b1;
        flush   = 1'b0;
        hold    = 1'b0;
        start   = 1'b0;
        op      = 3'd0;
        rs1_val = 32'd0;
        rs2_val = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result, 32'd0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        issue(T_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 33);
        issue(T_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 33);
        issue(T_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0, 33);
        issue(T_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0, 33);
        issue(T_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0, 33);
        issue(T_DIVU,   32'd100,        32'd7,         32'd14,        0, 33);
        issue(T_REMU,   32'd100,        32'd7,         32'd2,         0, 33);
        issue(T_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 0, 1);
        issue(T_REMU,   32'd5,          32'd0,         32'd5,         0, 1);
        issue(T_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0, 1);
        issue(T_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0, 1);
        issue(T_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 3, 33);
        issue(T_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 3, 1);

        // Flush at cycle 10 of a DIV
        op = T_DIV; rs1_val = 32'd1000; rs2_val = 32'd7; start = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_stall", {31'd0, stall_req}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (result_valid) seen = 1'b1;
        end
        chk("flush_no_valid", {31'd0, seen}, 32'd0);
        issue(T_MUL, 32'd3, 32'd4, 32'd12, 0, 33);

        // Flush together with start in IDLE: op is not accepted
        op = T_MUL; rs1_val = 32'd9; rs2_val = 32'd9; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_start_stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);

        // Reset pulsed mid-CALC
        op = T_MUL; rs1_val = 32'd11; rs2_val = 32'd13; start = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_result", result, 32'd0);
        chk("midrst_valid", {31'd0, result_valid}, 32'd0);
        chk("midrst_stall", {31'd0, stall_req}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 20)); b = 32'($urandom_range(0, 20)); end
                3: b = 32'($urandom_range(1, 3));
                4: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            issue(o, a, b, ref_model(o, a, b), $urandom_range(0, 2), ref_latency(o, a, b));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
